// File: rtl/uart_reg_file.sv
// UART register bank: CR/SR/TDR/RDR/CDR state behind the offset decoder, one-byte TX/RX buffers,
// status/overrun tracking, registered read data and a level interrupt.

package uart_pkg;
    typedef enum logic [2:0] {
        UART_NONE = 3'd0,
        UART_CR   = 3'd1,
        UART_SR   = 3'd2,
        UART_TDR  = 3'd3,
        UART_RDR  = 3'd4,
        UART_CDR  = 3'd5
    } uart_reg_t;
endpackage

module uart_reg_file #(
    parameter logic [15:0] CDR_RESET = 16'd868
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic                  we,
    input  logic [31:0]           wdata,
    input  uart_pkg::uart_reg_t   requested_reg,
    output logic [31:0]           rdata,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [15:0]           clk_div,
    output logic                  tx_en,
    output logic                  rx_en,
    output logic                  irq
);
    import uart_pkg::*;

    logic [3:0]  r_cr;
    logic [7:0]  r_tdr;
    logic        r_tdr_full;
    logic [7:0]  r_rdr;
    logic        r_rxne;
    logic        r_rxovr;
    logic        r_txovf;
    logic [15:0] r_cdr;
    logic [31:0] r_rdata;
    logic        r_irq;

    logic        w_access;
    logic        w_wr;
    logic        w_rd;
    logic        w_cr_wr;
    logic        w_sr_wr;
    logic        w_tdr_wr;
    logic        w_cdr_wr;
    logic        w_rdr_rd;
    logic        w_tx_fire;
    logic        w_tdr_load;
    logic        w_tdr_drop;
    logic        w_rx_cap;
    logic        w_rx_ovr;
    logic        w_rxovr_clr;
    logic        w_txovf_clr;
    logic [31:0] w_sr_val;
    logic [31:0] w_rdata_nxt;
    logic        w_irq_nxt;
    logic        w_unused_wdata;

    assign w_access    = req && (requested_reg != UART_NONE);
    assign w_wr        = w_access && we;
    assign w_rd        = w_access && !we;
    assign w_cr_wr     = w_wr && (requested_reg == UART_CR);
    assign w_sr_wr     = w_wr && (requested_reg == UART_SR);
    assign w_tdr_wr    = w_wr && (requested_reg == UART_TDR);
    assign w_cdr_wr    = w_wr && (requested_reg == UART_CDR);
    assign w_rdr_rd    = w_rd && (requested_reg == UART_RDR);

    // A write that coincides with the handshake refills the buffer in the same edge
    assign w_tx_fire   = r_tdr_full && r_cr[0] && tx_ready;
    assign w_tdr_load  = w_tdr_wr && (!r_tdr_full || w_tx_fire);
    assign w_tdr_drop  = w_tdr_wr && r_tdr_full && !w_tx_fire;

    assign w_rx_cap    = r_cr[1] && rx_valid && (!r_rxne || w_rdr_rd);
    assign w_rx_ovr    = r_cr[1] && rx_valid && r_rxne && !w_rdr_rd;
    assign w_rxovr_clr = w_sr_wr && wdata[2];
    assign w_txovf_clr = w_sr_wr && wdata[4];

    assign w_sr_val    = {27'd0, r_txovf, !r_tdr_full, r_rxovr, r_rxne, (r_tdr_full || !tx_ready)};
    assign w_irq_nxt   = (r_cr[2] && r_rxne) || (r_cr[3] && !r_tdr_full) || r_rxovr || r_txovf;
    assign w_unused_wdata = &{1'b0, wdata[31:16]};

    // Read data selection from current (pre-update) register contents
    always_comb begin
        w_rdata_nxt = 32'd0;
        case (requested_reg)
            UART_CR:  w_rdata_nxt = {28'd0, r_cr};
            UART_SR:  w_rdata_nxt = w_sr_val;
            UART_TDR: w_rdata_nxt = 32'd0;
            UART_RDR: w_rdata_nxt = {24'd0, r_rdr};
            UART_CDR: w_rdata_nxt = {16'd0, r_cdr};
            default:  w_rdata_nxt = 32'd0;
        endcase
    end

    // Control and divider registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cr  <= 4'd0;
            r_cdr <= CDR_RESET;
        end else begin
            if (w_cr_wr) begin
                r_cr <= wdata[3:0];
            end
            if (w_cdr_wr) begin
                r_cdr <= wdata[15:0];
            end
        end
    end

    // Transmit buffer and its overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tdr      <= 8'd0;
            r_tdr_full <= 1'b0;
            r_txovf    <= 1'b0;
        end else begin
            if (w_tdr_load) begin
                r_tdr      <= wdata[7:0];
                r_tdr_full <= 1'b1;
            end else if (w_tx_fire) begin
                r_tdr_full <= 1'b0;
            end
            if (w_tdr_drop) begin
                r_txovf <= 1'b1;
            end else if (w_txovf_clr) begin
                r_txovf <= 1'b0;
            end
        end
    end

    // Receive buffer, not-empty and overrun flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdr   <= 8'd0;
            r_rxne  <= 1'b0;
            r_rxovr <= 1'b0;
        end else begin
            if (w_rx_cap) begin
                r_rdr  <= rx_data;
                r_rxne <= 1'b1;
            end else if (w_rdr_rd) begin
                r_rxne <= 1'b0;
            end
            if (w_rx_ovr) begin
                r_rxovr <= 1'b1;
            end else if (w_rxovr_clr) begin
                r_rxovr <= 1'b0;
            end
        end
    end

    // Registered read data and interrupt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= 32'd0;
            r_irq   <= 1'b0;
        end else begin
            if (w_rd) begin
                r_rdata <= w_rdata_nxt;
            end
            r_irq <= w_irq_nxt;
        end
    end

    assign rdata    = r_rdata;
    assign tx_data  = r_tdr;
    assign tx_valid = r_tdr_full && r_cr[0];
    assign clk_div  = r_cdr;
    assign tx_en    = r_cr[0];
    assign rx_en    = r_cr[1];
    assign irq      = r_irq;

endmodule

// File: tb/tb_uart_reg_file.sv
// Directed bench for uart_reg_file: bus accesses, TX/RX buffering, flags, irq and reset.

module tb_uart_reg_file;
    import uart_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [31:0] wdata;
    uart_reg_t   requested_reg;
    logic [31:0] rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [15:0] clk_div;
    logic        tx_en;
    logic        rx_en;
    logic        irq;

    int n_vec;
    int n_miss;

    uart_reg_file dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (req),
        .we            (we),
        .wdata         (wdata),
        .requested_reg (requested_reg),
        .rdata         (rdata),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .clk_div       (clk_div),
        .tx_en         (tx_en),
        .rx_en         (rx_en),
        .irq           (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input uart_reg_t r, input logic [31:0] d);
        req = 1'b1; we = 1'b1; wdata = d; requested_reg = r;
        step();
        req = 1'b0; we = 1'b0; wdata = 32'd0; requested_reg = UART_NONE;
    endtask

    task automatic bus_read(input uart_reg_t r, output logic [31:0] d);
        req = 1'b1; we = 1'b0; requested_reg = r;
        step();
        req = 1'b0; requested_reg = UART_NONE;
        d = rdata;
    endtask

    task automatic rx_strobe(input logic [7:0] b);
        rx_valid = 1'b1; rx_data = b;
        step();
        rx_valid = 1'b0; rx_data = 8'd0;
    endtask

    logic [31:0] rd;

    initial begin
        n_vec = 0; n_miss = 0;
        rst_n = 1'b0; req = 1'b0; we = 1'b0; wdata = 32'd0; requested_reg = UART_NONE;
        tx_ready = 1'b0; rx_data = 8'd0; rx_valid = 1'b0;
        #22;
        check("rst_rdata", rdata, 32'd0);
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_clk_div", {16'd0, clk_div}, 32'd868);
        check("rst_irq", {31'd0, irq}, 32'd0);
        rst_n = 1'b1;
        step();

        bus_read(UART_SR, rd);
        check("sr_after_reset", rd, 32'h0000_0009);

        // TX path: byte held while tx_ready low, overflow on second write
        bus_write(UART_CR, 32'h1);
        bus_write(UART_TDR, 32'h55);
        check("tx_valid_full", {31'd0, tx_valid}, 32'd1);
        check("tx_data_55", {24'd0, tx_data}, 32'h55);
        step(); step(); step();
        check("tx_valid_held", {31'd0, tx_valid}, 32'd1);
        bus_write(UART_TDR, 32'hAA);
        check("tx_data_not_aa", {24'd0, tx_data}, 32'h55);
        bus_read(UART_SR, rd);
        check("sr_txovf", rd, 32'h0000_0011);
        check("irq_txovf", {31'd0, irq}, 32'd1);
        bus_write(UART_SR, 32'h10);
        bus_read(UART_SR, rd);
        check("sr_txovf_clr", rd, 32'h0000_0001);
        check("tx_data_kept", {24'd0, tx_data}, 32'h55);
        tx_ready = 1'b1;
        step();
        check("tx_valid_accepted", {31'd0, tx_valid}, 32'd0);
        bus_read(UART_SR, rd);
        check("sr_tdre_after_accept", rd, 32'h0000_0008);

        // RX overrun: second byte discarded
        bus_write(UART_CR, 32'h3);
        rx_strobe(8'h3C);
        rx_strobe(8'h7E);
        bus_read(UART_RDR, rd);
        check("rdr_3c", rd, 32'h0000_003C);
        bus_read(UART_SR, rd);
        check("sr_rxovr", rd, 32'h0000_000C);
        check("irq_rxovr", {31'd0, irq}, 32'd1);
        bus_write(UART_SR, 32'h04);
        bus_read(UART_SR, rd);
        check("sr_rxovr_clr", rd, 32'h0000_0008);

        // RDR read coinciding with a new byte
        rx_strobe(8'h22);
        req = 1'b1; we = 1'b0; requested_reg = UART_RDR; rx_valid = 1'b1; rx_data = 8'h11;
        step();
        req = 1'b0; requested_reg = UART_NONE; rx_valid = 1'b0; rx_data = 8'd0;
        check("rdr_old_22", rdata, 32'h0000_0022);
        bus_read(UART_SR, rd);
        check("sr_rxne_stays", rd, 32'h0000_000A);
        bus_read(UART_RDR, rd);
        check("rdr_11", rd, 32'h0000_0011);

        // Overrun set and W1C clear in the same cycle: set wins
        rx_strobe(8'h33);
        req = 1'b1; we = 1'b1; wdata = 32'h04; requested_reg = UART_SR;
        rx_valid = 1'b1; rx_data = 8'h44;
        step();
        req = 1'b0; we = 1'b0; wdata = 32'd0; requested_reg = UART_NONE;
        rx_valid = 1'b0; rx_data = 8'd0;
        bus_read(UART_SR, rd);
        check("sr_set_wins", rd, 32'h0000_000E);
        bus_read(UART_RDR, rd);
        check("rdr_33_kept", rd, 32'h0000_0033);
        bus_write(UART_SR, 32'h04);

        // RXEN=0 ignores strobes
        bus_write(UART_CR, 32'h1);
        rx_strobe(8'h99);
        bus_read(UART_SR, rd);
        check("sr_rx_disabled", rd, 32'h0000_0008);

        // Interrupt timing and TXEN=0 hold
        bus_write(UART_CR, 32'hC);
        check("irq_not_yet", {31'd0, irq}, 32'd0);
        step();
        check("irq_tdre", {31'd0, irq}, 32'd1);
        bus_write(UART_TDR, 32'h5A);
        step();
        check("irq_dropped", {31'd0, irq}, 32'd0);
        check("tx_valid_txen0", {31'd0, tx_valid}, 32'd0);
        check("tx_data_5a", {24'd0, tx_data}, 32'h5A);
        bus_write(UART_CR, 32'h1);
        check("tx_valid_txen1", {31'd0, tx_valid}, 32'd1);
        step();
        check("tx_valid_sent", {31'd0, tx_valid}, 32'd0);

        // Divider, write-only and masked reads
        bus_write(UART_CDR, 32'h0001_2345);
        bus_read(UART_CDR, rd);
        check("cdr_read", rd, 32'h0000_2345);
        check("clk_div", {16'd0, clk_div}, 32'h2345);
        bus_read(UART_TDR, rd);
        check("tdr_reads_zero", rd, 32'd0);
        bus_write(UART_CR, 32'hFF);
        bus_read(UART_CR, rd);
        check("cr_masked", rd, 32'h0000_000F);
        check("tx_rx_en", {30'd0, rx_en, tx_en}, 32'h3);

        // Asynchronous reset while a byte is pending
        tx_ready = 1'b0;
        bus_write(UART_CR, 32'h1);
        bus_write(UART_TDR, 32'h77);
        check("tx_valid_pending", {31'd0, tx_valid}, 32'd1);
        rst_n = 1'b0;
        #2;
        check("mid_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("mid_rst_clk_div", {16'd0, clk_div}, 32'd868);
        check("mid_rst_rdata", rdata, 32'd0);
        #2;
        rst_n = 1'b1;
        step();
        bus_read(UART_SR, rd);
        check("sr_after_mid_rst", rd, 32'h0000_0009);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
